pool_stream: RTL and testbench

POOL_STREAM -- requirements
Module: pool_stream

---
 rtl/pool_pkg.sv | 17 +
 rtl/pool_stream_if.sv | 26 ++
 rtl/pool_cmp2.sv | 17 +
 rtl/pool_stream.sv | 165 ++++++++++++++++
 tb/tb_pool_stream.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// Shared constants for the 2x2 pooling stream: window positions and mode encoding.
package pool_pkg;

    localparam logic [1:0] POS_TL = 2'd0;
    localparam logic [1:0] POS_TR = 2'd1;
    localparam logic [1:0] POS_BL = 2'd2;
    localparam logic [1:0] POS_BR = 2'd3;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    // Index width that stays at least 1 bit even for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_stream_if.sv
// Pixel-in / pooled-result-out handshake bundle for pool_stream.
interface pool_stream_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic [1:0]        out_hist;
    logic              frame_done;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, out_addr, out_hist, frame_done
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, out_addr, out_hist, frame_done
    );
endinterface

// File: rtl/pool_cmp2.sv
// Unsigned 2-input max that carries the winner's window position; ties keep input a.
module pool_cmp2 #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        hist_a,
    input  logic [1:0]        hist_b,
    output logic [DATA_W-1:0] max_val,
    output logic [1:0]        hist
);
    logic take_b;

    assign take_b  = (b > a);
    assign max_val = take_b ? b : a;
    assign hist    = take_b ? hist_b : hist_a;
endmodule

// File: rtl/pool_stream.sv
// Streaming 2x2/stride-2 max (or average) pooling over a SIZE x SIZE raster frame.
// Define POOL_STREAM_AVG_EN to add average mode; otherwise the block is max-only.
module pool_stream #(
    parameter int DATA_W = 16,
    parameter int SIZE   = 6,
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    pool_stream_if.slave bus
);
    import pool_pkg::*;

    localparam int HALF = SIZE / 2;
    localparam int NOUT = HALF * HALF;
    localparam int CW   = idx_w(SIZE);
    localparam int SW   = idx_w(HALF);
    localparam int LBW  = DATA_W + 2;

    logic [CW-1:0]     col_reg, col_next;
    logic [CW-1:0]     row_reg, row_next;
    logic [ADDR_W-1:0] res_cnt_reg, res_cnt_next;
    logic [DATA_W-1:0] left_reg;
    logic [LBW-1:0]    line_buf [HALF];
    logic [LBW-1:0]    lb_rd_reg;

    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] out_data_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic [1:0]        out_hist_reg;

    logic              in_ready, xfer, col_odd, row_odd;
    logic              lb_we, lb_re, res_load;
    logic [SW-1:0]     slot;
    logic [LBW-1:0]    lb_wr_data;
    logic [DATA_W-1:0] pair_max, blk_max, res_data;
    logic [1:0]        pair_hist, blk_hist, res_hist;

    assign in_ready = !out_valid_reg || bus.out_ready;
    assign xfer     = bus.in_valid && in_ready;
    assign col_odd  = col_reg[0];
    assign row_odd  = row_reg[0];
    assign slot     = SW'(col_reg >> 1);
    assign lb_we    = xfer && !row_odd && col_odd;
    assign lb_re    = xfer && row_odd && !col_odd;
    assign res_load = xfer && row_odd && col_odd;

    // Pair stage: held even-column pixel against the current odd-column pixel.
    pool_cmp2 #(.DATA_W(DATA_W)) u_pair (
        .a      (left_reg),
        .b      (bus.in_data),
        .hist_a (row_odd ? POS_BL : POS_TL),
        .hist_b (row_odd ? POS_BR : POS_TR),
        .max_val(pair_max),
        .hist   (pair_hist)
    );

    // Row stage: buffered top pair against the bottom pair, top wins ties.
    pool_cmp2 #(.DATA_W(DATA_W)) u_row (
        .a      (lb_rd_reg[DATA_W-1:0]),
        .b      (pair_max),
        .hist_a (lb_rd_reg[LBW-1:DATA_W]),
        .hist_b (pair_hist),
        .max_val(blk_max),
        .hist   (blk_hist)
    );

`ifdef POOL_STREAM_AVG_EN
    logic              mode_reg;
    logic              avg_mode;
    logic              first_px;
    logic [DATA_W:0]   pair_sum;
    logic [LBW-1:0]    blk_sum;

    assign first_px = (row_reg == '0) && (col_reg == '0);
    // The first pixel of a frame decides the mode before it is latched.
    assign avg_mode = first_px ? (bus.mode == MODE_AVG) : mode_reg;
    assign pair_sum = {1'b0, left_reg} + {1'b0, bus.in_data};
    assign blk_sum  = lb_rd_reg + LBW'(pair_sum);

    always_ff @(posedge clk) begin
        if (!rst_n)
            mode_reg <= MODE_MAX;
        else if (xfer && first_px)
            mode_reg <= (bus.mode == MODE_AVG);
    end
`endif

    always_comb begin
        lb_wr_data = {pair_hist, pair_max};
        res_data   = blk_max;
        res_hist   = blk_hist;
`ifdef POOL_STREAM_AVG_EN
        if (avg_mode) begin
            lb_wr_data = LBW'(pair_sum);
            res_data   = blk_sum[LBW-1:2];
            res_hist   = POS_TL;
        end
`endif
    end

    always_comb begin
        col_next     = col_reg;
        row_next     = row_reg;
        res_cnt_next = res_cnt_reg;
        if (xfer) begin
            if (col_reg == CW'(SIZE - 1)) begin
                col_next = '0;
                row_next = (row_reg == CW'(SIZE - 1)) ? '0 : row_reg + CW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
        if (res_load)
            res_cnt_next = (res_cnt_reg == ADDR_W'(NOUT - 1)) ? '0 : res_cnt_reg + ADDR_W'(1);
    end

    always_comb begin
        out_valid_next = out_valid_reg;
        if (res_load)
            out_valid_next = 1'b1;
        else if (bus.out_ready)
            out_valid_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_reg       <= '0;
            row_reg       <= '0;
            res_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_addr_reg  <= '0;
            out_hist_reg  <= '0;
        end else begin
            col_reg       <= col_next;
            row_reg       <= row_next;
            res_cnt_reg   <= res_cnt_next;
            out_valid_reg <= out_valid_next;
            if (res_load) begin
                out_data_reg <= res_data;
                out_addr_reg <= res_cnt_reg;
                out_hist_reg <= res_hist;
            end
        end
    end

    // Line buffer with registered read; slot is fetched on the even column of an odd row.
    always_ff @(posedge clk) begin
        if (lb_we)
            line_buf[slot] <= lb_wr_data;
        if (lb_re)
            lb_rd_reg <= line_buf[slot];
        if (xfer && !col_odd)
            left_reg <= bus.in_data;
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_data   = out_data_reg;
    assign bus.out_addr   = out_addr_reg;
    assign bus.out_hist   = out_hist_reg;
    assign bus.frame_done = out_valid_reg && (out_addr_reg == ADDR_W'(NOUT - 1));

endmodule

// File: tb/tb_pool_stream.sv
// Bench for pool_stream: table-built frames, result scoreboard, stall/throttle and reset sequences.
module tb_pool_stream;
    localparam int DW   = 16;
    localparam int SZ   = 6;
    localparam int AW   = 6;
    localparam int NB   = 9;
    localparam int NPIX = SZ * SZ;

    typedef struct packed {
        logic [3:0][DW-1:0] px;
        logic [DW-1:0]      exp_max;
        logic [1:0]         exp_hist;
        logic [DW-1:0]      exp_avg;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [1:0]    hist;
        logic          done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pool_stream_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    pool_stream #(.DATA_W(DW), .SIZE(SZ), .ADDR_W(AW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    vec_t tbl [2*NB];
    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_miss = 0;
    logic hold_pend = 1'b0;
    exp_t held;
    int   rdy_mode = 0;
    int   stall_left = 0;
    logic stall_used = 1'b0;

    function automatic vec_t mk(input logic [DW-1:0] tl, tr, bl, br, mx,
                                input logic [1:0] h, input logic [DW-1:0] av);
        vec_t v;
        v.px[0] = tl; v.px[1] = tr; v.px[2] = bl; v.px[3] = br;
        v.exp_max = mx; v.exp_hist = h; v.exp_avg = av;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // out_ready: 0 = always ready, 1 = random, 2 = five-cycle stall after the first result.
    always @(posedge clk) begin
        #1;
        if (rdy_mode != 2) stall_used = 1'b0;
        if (rdy_mode == 1) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end else if (rdy_mode == 2 && stall_left > 0) begin
            stall_left--;
            bus.out_ready = (stall_left == 0);
        end else if (rdy_mode == 2 && !stall_used && bus.out_valid) begin
            stall_used = 1'b1;
            stall_left = 5;
            bus.out_ready = 1'b0;
        end else begin
            bus.out_ready = 1'b1;
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else if (bus.out_valid) begin
            if (hold_pend) begin
                check("hold_data", bus.out_data, held.data);
                check("hold_addr", bus.out_addr, held.addr);
                check("hold_hist", bus.out_hist, held.hist);
            end
            if (bus.out_ready) begin
                hold_pend = 1'b0;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL extra_result: got addr %0d data %0h, expected no result",
                             bus.out_addr, bus.out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("result addr=%0d data=%0h hist=%0d done=%0b", bus.out_addr,
                             bus.out_data, bus.out_hist, bus.frame_done);
                    check("out_data", bus.out_data, e.data);
                    check("out_addr", bus.out_addr, e.addr);
                    check("out_hist", bus.out_hist, e.hist);
                    check("frame_done", bus.frame_done, e.done);
                end
            end else begin
                check("stall_in_ready", bus.in_ready, 0);
                hold_pend = 1'b1;
                held = {bus.out_data, bus.out_addr, bus.out_hist, bus.frame_done};
            end
        end else begin
            hold_pend = 1'b0;
            check("idle_frame_done", bus.frame_done, 0);
        end
    end

    task automatic send_px(input logic [DW-1:0] v, input logic m, output logic ok);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        bus.mode     = m;
        ok = 1'b0;
        for (int w = 0; w < 100 && !ok; w++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 100 cycles, expected 1");
        end
    endtask

    task automatic drive_frame(input int base, input logic fmode, input logic toggle,
                               input logic gaps, input int npix);
        for (int p = 0; p < npix; p++) begin
            int   r, c, b, pos;
            logic m, ok;
            exp_t e;
            r   = p / SZ;
            c   = p % SZ;
            b   = (r / 2) * (SZ / 2) + c / 2;
            pos = (r % 2) * 2 + (c % 2);
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            m = (p == 0) ? fmode : (toggle ? 1'($urandom_range(0, 1)) : fmode);
            send_px(tbl[base+b].px[pos], m, ok);
            if (ok && pos == 3) begin
                e.data = tbl[base+b].exp_max;
                e.hist = tbl[base+b].exp_hist;
`ifdef POOL_STREAM_AVG_EN
                if (fmode) begin
                    e.data = tbl[base+b].exp_avg;
                    e.hist = 2'd0;
                end
`endif
                e.addr = AW'(b);
                e.done = (b == NB - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        for (int w = 0; w < 300 && exp_q.size() != 0; w++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_out_hist", bus.out_hist, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mode     = 1'b0;

        // Ramp frame 0..35: block with top-left t holds t,t+1,t+6,t+7 -> max t+7 at BR, avg t+3.
        for (int i = 0; i < NB; i++) begin
            logic [DW-1:0] t;
            t = DW'(12 * (i / 3) + 2 * (i % 3));
            tbl[i] = mk(t, t + 1, t + 6, t + 7, t + 7, 2'd3, t + 3);
        end
        tbl[NB+0] = mk(5, 5, 5, 5, 5, 2'd0, 5);
        tbl[NB+1] = mk(1, 9, 9, 2, 9, 2'd1, 5);
        tbl[NB+2] = mk(1, 2, 3, 6, 6, 2'd3, 3);
        tbl[NB+3] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'd0, 16'hFFFF);
        tbl[NB+4] = mk(3, 3, 7, 7, 7, 2'd2, 5);
        tbl[NB+5] = mk(8, 2, 8, 9, 9, 2'd3, 6);
        tbl[NB+6] = mk(4, 4, 1, 1, 4, 2'd0, 2);
        tbl[NB+7] = mk(2, 7, 7, 7, 7, 2'd1, 5);
        tbl[NB+8] = mk(16'h8000, 16'h7FFF, 1, 0, 16'h8000, 2'd0, 16'h4000);

        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;

        // Back-to-back frames with mid-frame mode toggling.
        drive_frame(0, 1'b0, 1'b0, 1'b0, NPIX);
        drive_frame(NB, 1'b0, 1'b1, 1'b0, NPIX);
        drive_frame(NB, 1'b1, 1'b1, 1'b0, NPIX);
        drive_frame(0, 1'b1, 1'b0, 1'b0, NPIX);
        drain();

        rdy_mode = 2;
        drive_frame(0, 1'b0, 1'b0, 1'b0, NPIX);
        drain();
        check("stall_seen", stall_used, 1);

        rdy_mode = 1;
        drive_frame(NB, 1'b0, 1'b0, 1'b1, NPIX);
        drain();
        rdy_mode = 0;

        // Reset after 20 pixels, then a fresh frame must restart at address 0.
        drive_frame(0, 1'b0, 1'b0, 1'b0, 20);
        drain();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        drive_frame(NB, 1'b0, 1'b0, 1'b0, NPIX);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
